// File: rtl/nand_gate.sv
// Bitwise NAND with a combinational output, a 1-cycle registered output and valid flag.
// Optional all-zero-result statistics counter, built only when NAND_GATE_STATS_EN is defined.
module nand_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] zero_cnt
);

    logic [WIDTH-1:0] y_q_reg;
    logic             out_valid_reg;

    // Purely combinational path: no dependence on clk, rst or in_valid.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_nand_bit
            assign y[gi] = ~(a[gi] & b[gi]);
        end
    endgenerate

    // Reset value is the NAND of all-zero operands; a valid in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_reg       <= '1;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                y_q_reg <= y;
            end
        end
    end

    assign y_q       = y_q_reg;
    assign out_valid = out_valid_reg;

`ifdef NAND_GATE_STATS_EN
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             result_zero;

    assign result_zero = ~|y;

    // Clear beats increment; the count sticks at its maximum value.
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (in_valid && result_zero && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign zero_cnt = cnt_reg;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign zero_cnt       = '0;
`endif

endmodule

// File: tb/tb_nand_gate.sv
// Randomized self-checking bench for nand_gate: a WIDTH=1/CNT_W=2 instance and a
// WIDTH=8/CNT_W=16 instance, both compared against a truth-table reference model.
module tb_nand_gate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a1, b1, v1, clr1;
    logic        y1, yq1, ov1;
    logic [1:0]  cnt1;
    logic [7:0]  a8, b8, y8, yq8;
    logic        v8, clr8, ov8;
    logic [15:0] cnt8;

    int checks   = 0;
    int failures = 0;

`ifdef NAND_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Reference truth table indexed by {a_bit, b_bit}.
    bit tt [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Reference model state.
    logic       m_yq1, m_ov1, m_ov8;
    logic [7:0] m_yq8;
    int         m_cnt1, m_cnt8;

    nand_gate #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
        .y(y1), .y_q(yq1), .out_valid(ov1), .cnt_clr(clr1), .zero_cnt(cnt1)
    );

    nand_gate #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
        .y(y8), .y_q(yq8), .out_valid(ov8), .cnt_clr(clr8), .zero_cnt(cnt8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_nand(input logic [7:0] x, input logic [7:0] z, input int w);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < w; i++) r[i] = tt[{x[i], z[i]}];
        return r;
    endfunction

    // One clock cycle: drive, check y combinationally, clock, update model, check registers.
    task automatic step(input logic ia1, input logic ib1, input logic iv1, input logic ic1,
                        input logic [7:0] ia8, input logic [7:0] ib8, input logic iv8, input logic ic8);
        logic [7:0] r1, r8;
        a1 = ia1; b1 = ib1; v1 = iv1; clr1 = ic1;
        a8 = ia8; b8 = ib8; v8 = iv8; clr8 = ic8;
        r1 = ref_nand({7'b0, ia1}, {7'b0, ib1}, 1);
        r8 = ref_nand(ia8, ib8, 8);
        #1;
        check("y1", 32'(y1), 32'(r1[0]));
        check("y8", 32'(y8), 32'(r8));
        @(posedge clk);
        if (rst) begin
            m_yq1 = 1'b1; m_ov1 = 1'b0; m_cnt1 = 0;
            m_yq8 = 8'hFF; m_ov8 = 1'b0; m_cnt8 = 0;
        end else begin
            m_ov1 = iv1;
            if (iv1) m_yq1 = r1[0];
            m_ov8 = iv8;
            if (iv8) m_yq8 = r8;
            if (STATS) begin
                if (ic1) m_cnt1 = 0;
                else if (iv1 && r1[0] == 1'b0 && m_cnt1 < 3) m_cnt1++;
                if (ic8) m_cnt8 = 0;
                else if (iv8 && r8 == 8'h00 && m_cnt8 < 65535) m_cnt8++;
            end
        end
        #1;
        check("yq1", 32'(yq1), 32'(m_yq1));
        check("ov1", 32'(ov1), 32'(m_ov1));
        check("cnt1", 32'(cnt1), 32'(m_cnt1));
        check("yq8", 32'(yq8), 32'(m_yq8));
        check("ov8", 32'(ov8), 32'(m_ov8));
        check("cnt8", 32'(cnt8), 32'(m_cnt8));
        $display("step a1=%b b1=%b v1=%b clr1=%b a8=%h b8=%h v8=%b y_q8=%h cnt1=%0d cnt8=%0d",
                 ia1, ib1, iv1, ic1, ia8, ib8, iv8, yq8, cnt1, cnt8);
    endtask

    initial begin
        logic       ra, rb, rv, rc;
        logic [7:0] ra8, rb8;
        logic       rv8, rc8;

        // Reset with in_valid asserted: y keeps tracking, valids are dropped.
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h0F, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        rst = 1'b0;

        // Back-to-back valid across the full truth table, then a bubble.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 8'hCC, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h3C, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0);

        // Counter clear, then five zero-result cycles to reach saturation on the narrow counter.
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        // Clear wins over a simultaneous increment.
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);

        for (int i = 0; i < 300; i++) begin
            ra  = 1'($urandom);
            rb  = 1'($urandom);
            rv  = ($urandom % 4) != 0;
            rc  = ($urandom % 16) == 0;
            ra8 = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom);
            rb8 = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom);
            rv8 = ($urandom % 4) != 0;
            rc8 = ($urandom % 32) == 0;
            rst = ($urandom % 50) == 0;
            step(ra, rb, rv, rc, ra8, rb8, rv8, rc8);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nand_gate.md
NAND_GATE -- requirements
Module: nand_gate

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the bit width of a, b, y and y_q.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the statistics counter.
REQ-003 Port clk, input, 1 bit, SHALL be the single rising-edge clock.
REQ-004 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port a, input, WIDTH bits, SHALL be the first operand.
REQ-006 Port b, input, WIDTH bits, SHALL be the second operand.
REQ-007 Port in_valid, input, 1 bit, SHALL qualify a/b for the registered path.
REQ-008 Port y, output, WIDTH bits, SHALL be the combinational NAND result.
REQ-009 Port y_q, output, WIDTH bits, SHALL be the registered NAND result.
REQ-010 Port out_valid, output, 1 bit, SHALL flag that y_q holds a new result this cycle.
REQ-011 Port cnt_clr, input, 1 bit, SHALL clear the statistics counter synchronously.
REQ-012 Port zero_cnt, output, CNT_W bits, SHALL be the statistics counter value.

Function
REQ-013 y SHALL equal bitwise ~(a & b) at all times, with zero clock latency and independent of clk, rst and in_valid.
REQ-014 Truth table per bit SHALL be: 00->1, 01->1, 10->1, 11->0.
REQ-015 On a rising clk edge with in_valid=1 and rst=0, y_q SHALL load ~(a & b) and out_valid SHALL be 1 in the next cycle; latency is exactly 1 cycle.
REQ-016 With in_valid=0, y_q SHALL hold its value and out_valid SHALL be 0 in the next cycle.
REQ-017 Back-to-back in_valid=1 SHALL produce one result per cycle, with no bubbles.
REQ-018 X/Z handling is out of scope: inputs SHALL be treated as 2-state.

Reset
REQ-019 While rst=1 at a rising edge, y_q SHALL become all ones (the NAND of all-zero operands), out_valid 0 and zero_cnt 0.
REQ-020 rst SHALL take priority over in_valid and cnt_clr; an in_valid asserted in the same cycle as rst SHALL be dropped.
REQ-021 rst SHALL NOT affect the combinational output y.

Configuration
REQ-022 Macro NAND_GATE_STATS_EN SHALL enable the statistics counter.
REQ-023 With NAND_GATE_STATS_EN defined, zero_cnt SHALL increment by 1 on each accepted in_valid cycle whose result is all zeros (a and b all ones).
REQ-024 The counter SHALL saturate at 2^CNT_W-1.
REQ-025 cnt_clr=1 SHALL zero the counter and SHALL take priority over an increment in the same cycle.
REQ-026 Without NAND_GATE_STATS_EN, zero_cnt SHALL be constant 0, cnt_clr SHALL be ignored, and no counter logic SHALL exist.

Verification
REQ-027 WIDTH=1: apply a/b = 00, 01, 10, 11 for 10 ns each -> y = 1, 1, 1, 0, settling within each step with no clock edge needed.
REQ-028 rst=1 for 2 cycles, then 0 -> y_q=1, out_valid=0, zero_cnt=0; y still tracks a/b during reset.
REQ-029 in_valid=1 for 4 consecutive cycles with a/b=00, 01, 10, 11 -> y_q = 1, 1, 1, 0 on the 4 following cycles with out_valid=1 each cycle, then 0 once in_valid drops.
REQ-030 STATS_EN, CNT_W=2: 5 accepted cycles with a=b=1 -> zero_cnt = 1, 2, 3, 3, 3 (saturates).
REQ-031 STATS_EN: cnt_clr=1 together with in_valid=1 and a=b=1 -> zero_cnt=0 on the next cycle.
REQ-032 WIDTH=8: a=8'hF0, b=8'hCC -> y=8'h3F; with in_valid=1, y_q=8'h3F one cycle later.
